// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single regfile write port between the WB stage and
//   long-latency (LL) results (mul/div, uncached load return). WB always
//   owns the port; LL writes are queued in an in-order FIFO and drained on
//   WB-idle cycles, or bypassed straight through when the FIFO is empty and
//   WB is idle. A full-word WB write kills queued entries for the same dest,
//   because the WB write is younger. busy_mask exports the live FIFO dests so
//   that ID can interlock on them.
//
//   Optional macro RF_ARB_STARVE_EN: after STARVE_LIMIT consecutive WB writes
//   with a non-empty FIFO, the head is forced out and wb_stall asks WB to hold.
//
// Ports
//   clk, resetn                   clock, async active-low reset
//   wb_we/wb_waddr/wb_wdata       WB write (wb_we==0 : no write)
//   ll_valid/ll_ready             LL handshake (ll_ready = !full)
//   ll_we/ll_waddr/ll_wdata       LL write payload
//   rf_we/rf_waddr/rf_wdata       regfile write port
//   busy_mask                     one bit per register with a live queued write
//   fifo_count                    occupied entries, including cancelled ones
//   wb_stall                      WB hold request (0 unless the macro is defined)
module rf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [3:0]                 wb_we,
  input  logic [4:0]                 wb_waddr,
  input  logic [31:0]                wb_wdata,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [3:0]                 ll_we,
  input  logic [4:0]                 ll_waddr,
  input  logic [31:0]                ll_wdata,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       wb_stall
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ll_ent_t;

  ll_ent_t          mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic empty, full, wb_req, force_pop, wb_win, pop, bypass, push, cancel;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign wb_req = (wb_we != 4'h0);

`ifdef RF_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [SW-1:0] starve_cnt;

  assign force_pop = !empty && (starve_cnt == SW'(STARVE_LIMIT));

  // Counts WB cycles that keep a non-empty FIFO from draining; any pop or
  // an empty FIFO restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             starve_cnt <= '0;
    else if (empty || pop)   starve_cnt <= '0;
    else if (wb_req)         starve_cnt <= starve_cnt + SW'(1);
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^STARVE_LIMIT;
  assign force_pop = 1'b0;
`endif

  assign wb_stall = force_pop;
  assign wb_win   = wb_req && !force_pop;
  assign pop      = !empty && !wb_win;
  assign bypass   = empty && !wb_req && ll_valid;
  // Readiness is judged on the current count only: a pop at full does not
  // make room for a same-cycle push.
  assign ll_ready = resetn && !full;
  // Zero-enable or $0 requests are accepted but never stored.
  assign push     = ll_valid && !full && !bypass &&
                    (ll_we != 4'h0) && (ll_waddr != 5'd0);
  // A stalled WB write is not landing this cycle, so it cancels nothing yet.
  assign cancel   = wb_win && (wb_we == 4'hF);

  always_comb begin
    rf_we    = 4'h0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    if (resetn) begin
      if (wb_win) begin
        rf_we    = wb_we;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (pop) begin
        // A cancelled head still burns its slot, but writes nothing.
        if (live[head]) begin
          rf_we    = mem[head].we;
          rf_waddr = mem[head].waddr;
          rf_wdata = mem[head].wdata;
        end
      end else if (bypass) begin
        rf_we    = ll_we;
        rf_waddr = ll_waddr;
        rf_wdata = ll_wdata;
      end
    end
  end

  always_comb begin
    busy_mask = 32'h0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) busy_mask = busy_mask | (32'h1 << mem[i].waddr);
    busy_mask[0] = 1'b0;
  end

  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{we: ll_we, waddr: ll_waddr, wdata: ll_wdata};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      live  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cancel && live[i] && (mem[i].waddr == wb_waddr)) live[i] <= 1'b0;
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + PW'(1);
      end
      // Written last so a same-cycle cancel never hits the new entry.
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + PW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule
